data_memory_controller: RTL
===========================

DATA_MEMORY_CONTROLLER -- requirements
Module: data_memory_controller

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter DEPTH, default 32, SHALL set the number of 32-bit words (power of two, 4..1024).
REQ-003 Parameter LATENCY, default 1, SHALL set the wait cycles between accept and response (0..15).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_write  in  1  1=store, 0=load.
REQ-009 req_funct3  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 resp_valid  out  1  response present.
REQ-013 resp_ready  in  1  consumer accepts response.
REQ-014 resp_rdata  out  32  load result, extended to 32 bits.
REQ-015 resp_fault  out  1  request was rejected.
REQ-016 initial_values  in  32 x DEPTH  contents loaded during reset.
REQ-017 memory_check  out  32 x DEPTH  current contents, combinational.

Function
REQ-018 FSM states SHALL be IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE with reset low.
REQ-019 A request SHALL be accepted on an edge where req_valid && req_ready; all request fields are captured then.
REQ-020 On accept: LATENCY=0 goes to RESP; otherwise WAIT with counter loaded to LATENCY-1.
REQ-021 In WAIT the counter SHALL decrement each edge; at 0 the next edge goes to RESP.
REQ-022 resp_valid SHALL first be high in the cycle after edge E0+LATENCY, where E0 is the accept edge.
REQ-023 In RESP, resp_valid, resp_rdata and resp_fault SHALL hold stable until an edge with resp_ready=1, then return to IDLE; no new accept on that edge.
REQ-024 Word index SHALL be req_addr[31:2]; index >= DEPTH SHALL fault.
REQ-025 Misalignment SHALL fault: H/HU with addr[0]=1; W with addr[1:0]!=0.
REQ-026 funct3 011/110/111 SHALL fault; for stores 100/101 SHALL also fault.
REQ-027 A store SHALL commit on the edge entering RESP: B writes lane addr[1:0] with wdata[7:0]; H writes lane addr[1] with wdata[15:0]; W writes all 32 bits; other lanes unchanged.
REQ-028 A load SHALL sample memory on the edge entering RESP: B/H sign-extend, BU/HU zero-extend, W unmodified.
REQ-029 A store response SHALL return resp_rdata=0.
REQ-030 A faulting request SHALL never write memory, returns resp_rdata=0, resp_fault=1, and SHALL still take full LATENCY.
REQ-031 req_valid while not ready SHALL be ignored; the requester holds it.

Reset
REQ-032 While reset is high: state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_fault 0, req_ready 0; memory[i] = initial_values[i] for all i.
REQ-033 Reset asserted in WAIT or RESP SHALL drop the request with no memory write and no response.
REQ-034 The first accept SHALL be possible on the first edge after reset deasserts.

Verification
REQ-035 LATENCY=1, mem[1]=0x80FF7F01; LB addr 0x7 -> rdata 0xFFFFFF80 after E0+1; LBU addr 0x7 -> 0x00000080.
REQ-036 LATENCY=0; SH wdata 0x1234ABCD addr 0x6 into mem[1]=0x80FF7F01 -> mem[1]=0xABCD7F01; resp_valid after E0, rdata 0.
REQ-037 LW addr 0x5 -> resp_fault=1, rdata 0, memory unchanged; SW addr 0x80 with DEPTH=32 -> fault, no write.
REQ-038 LATENCY=3, resp_ready held low 4 cycles -> resp_valid high from after E0+3 until release edge; req_ready 0 throughout.
REQ-039 Assert reset during WAIT of SW 0xDEADBEEF to addr 0x0 -> mem[0]=initial_values[0], resp_valid stays 0.
REQ-040 Back-to-back SW 0x11 then LW, same address, resp_ready tied 1 -> load returns 0x00000011.

Source files
------------

// File: rtl/data_memory_controller.sv
// data_memory_controller: word-organised data memory serving RV32I byte,
// halfword and word loads/stores with a fixed response latency. Rejected
// requests (bad width code, misalignment, out-of-range index) are reported
// through resp_fault and never modify memory.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where resp_valid && resp_ready, and
// resp_valid/resp_rdata/resp_fault hold stable until that edge.
module data_memory_controller #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_fault,
  input  logic [32*DEPTH-1:0]  initial_values,
  output logic [32*DEPTH-1:0]  memory_check,
  output logic [1:0]           dbg_state
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         write_q, write_d;
  logic [2:0]   funct3_q, funct3_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic         resp_valid_q, resp_valid_d;
  logic [31:0]  resp_rdata_q, resp_rdata_d;
  logic         resp_fault_q, resp_fault_d;
  logic [31:0]  mem_q [DEPTH];
  logic [31:0]  mem_d [DEPTH];

  logic         accept;
  logic         enter_resp;
  logic         op_write;
  logic [2:0]   op_funct3;
  logic [31:0]  op_addr;
  logic [31:0]  op_wdata;
  logic [IW-1:0] widx;
  logic         range_fault;
  logic         code_fault;
  logic         op_fault;
  logic [31:0]  rd_word;
  logic [7:0]   rd_byte;
  logic [15:0]  rd_half;
  logic [31:0]  load_val;
  logic [31:0]  wr_word;

  assign req_ready  = (state_q == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;
  assign dbg_state  = state_q;

  // The edge entering RESP executes the access; with zero latency that is the
  // accept edge itself, so the live request fields are used instead of the copy.
  always_comb begin
    enter_resp = (accept && (LATENCY == 0)) || ((state_q == WAIT) && (cnt_q == 4'd0));
    if (state_q == IDLE) begin
      op_write  = req_write;
      op_funct3 = req_funct3;
      op_addr   = req_addr;
      op_wdata  = req_wdata;
    end else begin
      op_write  = write_q;
      op_funct3 = funct3_q;
      op_addr   = addr_q;
      op_wdata  = wdata_q;
    end
  end

  // Decode the access: word index, fault conditions, load extraction, store merge.
  always_comb begin
    widx        = op_addr[IW+1:2];
    range_fault = ({2'b00, op_addr[31:2]} >= 32'(DEPTH));
    unique case (op_funct3)
      3'b000:  code_fault = 1'b0;
      3'b001:  code_fault = op_addr[0];
      3'b010:  code_fault = (op_addr[1:0] != 2'b00);
      3'b100:  code_fault = op_write;
      3'b101:  code_fault = op_write || op_addr[0];
      default: code_fault = 1'b1;
    endcase
    op_fault = range_fault || code_fault;

    rd_word = mem_q[widx];
    rd_byte = rd_word[{op_addr[1:0], 3'b000} +: 8];
    rd_half = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (op_funct3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'd0, rd_byte};
      3'b101:  load_val = {16'd0, rd_half};
      default: load_val = 32'd0;
    endcase

    wr_word = rd_word;
    unique case (op_funct3)
      3'b000: wr_word[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
      3'b001: wr_word[{op_addr[1], 4'b0000} +: 16] = op_wdata[15:0];
      3'b010: wr_word = op_wdata;
      default: wr_word = rd_word;
    endcase
  end

  // Next-state logic: FSM sequencing, request capture, response and memory update.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    mem_d        = mem_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'd0;
          resp_fault_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      resp_valid_d = 1'b1;
      resp_fault_d = op_fault;
      resp_rdata_d = (op_fault || op_write) ? 32'd0 : load_val;
      if (!op_fault && op_write) begin
        mem_d[widx] = wr_word;
      end
    end
  end

  // State registers; reset reloads memory from initial_values and drops any request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_fault_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= initial_values[32*i +: 32];
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      mem_q        <= mem_d;
    end
  end

  // Flatten the memory contents onto the observation port.
  always_comb begin
    memory_check = '0;
    for (int i = 0; i < DEPTH; i++) begin
      memory_check[32*i +: 32] = mem_q[i];
    end
  end

endmodule
